// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// instr_encoder : packs RV32 instruction fields into 32-bit words behind a
//                 one-stage valid/ready register, tagging each with a PC.
//                 Optional macro IMM_RANGE_CHECK_EN adds immediate range checks.
// Revision      : 1.0
// ============================================================================

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ARCH_REG_INDEX_SIZE
`define ARCH_REG_INDEX_SIZE 5
`endif

module instr_encoder #(
    parameter logic [31:0] BASE_PC = 32'h0000_0200,
    parameter int unsigned PC_STEP = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            clear,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [2:0]                      in_fmt,
    input  logic [6:0]                      in_opcode,
    input  logic [2:0]                      in_funct3,
    input  logic [6:0]                      in_funct7,
    input  logic [`ARCH_REG_INDEX_SIZE-1:0] in_rd,
    input  logic [`ARCH_REG_INDEX_SIZE-1:0] in_rs1,
    input  logic [`ARCH_REG_INDEX_SIZE-1:0] in_rs2,
    input  logic [`WORD_SIZE-1:0]           in_imm,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [`WORD_SIZE-1:0]           out_instr,
    output logic [`WORD_SIZE-1:0]           out_pc,
    output logic                            out_err,
    output logic [15:0]                     out_count
);

    localparam logic [2:0]  FMT_R     = 3'd0;
    localparam logic [2:0]  FMT_I     = 3'd1;
    localparam logic [2:0]  FMT_S     = 3'd2;
    localparam logic [2:0]  FMT_B     = 3'd3;
    localparam logic [2:0]  FMT_U     = 3'd4;
    localparam logic [2:0]  FMT_J     = 3'd5;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INC    = 32'(PC_STEP);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q,    pc_d;
    logic        err_q,   err_d;
    logic [15:0] count_q, count_d;

    logic [31:0] enc_instr;
    logic        fmt_err;
    logic        imm_err;
    logic        accept;
    logic        handshake;

    always_comb begin
        enc_instr = NOP_INSTR;
        fmt_err   = 1'b0;
        case (in_fmt)
            FMT_R: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I: enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S: enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:0], in_opcode};
            FMT_B: enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:1], in_imm[11], in_opcode};
            FMT_U: enc_instr = {in_imm[31:12], in_rd, in_opcode};
            FMT_J: enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                in_rd, in_opcode};
            default: begin
                enc_instr = NOP_INSTR;
                fmt_err   = 1'b1;
            end
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // An immediate fits when every bit above its sign bit equals the sign bit.
    always_comb begin
        imm_err = 1'b0;
        case (in_fmt)
            FMT_I, FMT_S: imm_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            FMT_B:        imm_err = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
            FMT_J:        imm_err = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
            FMT_U:        imm_err = |in_imm[11:0];
            default:      imm_err = 1'b0;
        endcase
    end
`else
    assign imm_err = 1'b0;
`endif

    assign in_ready  = (!valid_q || out_ready) && !clear;
    assign accept    = in_valid && in_ready;
    assign handshake = valid_q && out_ready;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        err_d   = err_q;
        count_d = count_q;
        if (clear) begin
            valid_d = 1'b0;
            instr_d = '0;
            err_d   = 1'b0;
            pc_d    = BASE_PC;
            count_d = '0;
        end else begin
            // PC advances when a word leaves, so it always names the presented word.
            if (handshake) begin
                valid_d = 1'b0;
                pc_d    = pc_q + PC_INC;
                if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'd1;
                end
            end
            if (accept) begin
                valid_d = 1'b1;
                instr_d = enc_instr;
                err_d   = fmt_err || imm_err;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= BASE_PC;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = pc_q;
    assign out_err   = err_q;
    assign out_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// tb_instr_encoder : directed and randomized self-checking bench for
//                    instr_encoder against an arithmetic field-packing model.
// Revision         : 1.0
// ============================================================================

module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_0200;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_err;
    logic [15:0] out_count;

    int checks   = 0;
    int failures = 0;

    // Model of what the consumer should be seeing.
    bit        m_valid;
    bit [31:0] m_instr;
    bit        m_err;
    bit [31:0] m_pc;
    int        m_cnt;

    instr_encoder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_err   (out_err),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit [31:0] field(input bit [31:0] u, input int hi, input int lo);
        return (u >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    function automatic bit [31:0] ref_enc(input bit [2:0] fmt, input bit [6:0] op,
                                          input bit [2:0] f3, input bit [6:0] f7,
                                          input bit [4:0] rd, input bit [4:0] rs1,
                                          input bit [4:0] rs2, input bit [31:0] u);
        bit [31:0] w;
        w = 32'(op);
        case (fmt)
            3'd0: w += (32'(rd) << 7) + (32'(f3) << 12) + (32'(rs1) << 15)
                     + (32'(rs2) << 20) + (32'(f7) << 25);
            3'd1: w += (32'(rd) << 7) + (32'(f3) << 12) + (32'(rs1) << 15)
                     + (field(u, 11, 0) << 20);
            3'd2: w += (field(u, 4, 0) << 7) + (32'(f3) << 12) + (32'(rs1) << 15)
                     + (32'(rs2) << 20) + (field(u, 11, 5) << 25);
            3'd3: w += (field(u, 11, 11) << 7) + (field(u, 4, 1) << 8) + (32'(f3) << 12)
                     + (32'(rs1) << 15) + (32'(rs2) << 20) + (field(u, 10, 5) << 25)
                     + (field(u, 12, 12) << 31);
            3'd4: w += (32'(rd) << 7) + (u & 32'hFFFF_F000);
            3'd5: w += (32'(rd) << 7) + (u & 32'h000F_F000) + (field(u, 11, 11) << 20)
                     + (field(u, 10, 1) << 21) + (field(u, 20, 20) << 31);
            default: w = 32'h0000_0013;
        endcase
        return w;
    endfunction

    function automatic bit ref_err(input bit [2:0] fmt, input bit [31:0] u);
        bit e;
        int s;
        s = int'(u);
        e = (fmt > 3'd5);
`ifdef IMM_RANGE_CHECK_EN
        case (fmt)
            3'd1, 3'd2: e = (s < -2048) || (s > 2047);
            3'd3:       e = (s < -4096) || (s > 4094) || (u % 2 != 0);
            3'd5:       e = (s < -1048576) || (s > 1048574) || (u % 2 != 0);
            3'd4:       e = (u % 4096) != 0;
            default:    e = e;
        endcase
`else
        s = s;
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_bundle(input bit [2:0] fmt, input bit [6:0] op, input bit [2:0] f3,
                              input bit [6:0] f7, input bit [4:0] rd, input bit [4:0] rs1,
                              input bit [4:0] rs2, input bit [31:0] imm);
        in_fmt    = fmt;
        in_opcode = op;
        in_funct3 = f3;
        in_funct7 = f7;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
    endtask

    task automatic rand_bundle();
        int mode;
        int v;
        bit [31:0] imm;
        mode = int'($urandom_range(0, 3));
        case (mode)
            0:       imm = $urandom;
            1:       begin v = int'($urandom_range(0, 8191)) - 4096; imm = 32'(v); end
            2:       imm = $urandom & 32'hFFFF_F000;
            default: begin v = int'($urandom_range(0, 2097151)) - 1048576; imm = 32'(v); end
        endcase
        set_bundle(($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1))
                                               : 3'($urandom_range(0, 5)),
                   7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom),
                   5'($urandom), 5'($urandom), imm);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_instr = '0;
        m_err   = 1'b0;
        m_pc    = BASE;
        m_cnt   = 0;
    endtask

    // One clock: check in_ready, advance the model across the edge, check outputs.
    task automatic tick();
        bit exp_ready, acc, hs, clr;
        bit [31:0] nxt_instr;
        bit nxt_err;
        #1;
        clr       = clear;
        exp_ready = (!m_valid || out_ready) && !clr;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        acc       = in_valid && exp_ready;
        hs        = m_valid && out_ready;
        nxt_instr = ref_enc(in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);
        nxt_err   = ref_err(in_fmt, in_imm);
        @(posedge clk);
        #1;
        if (clr) begin
            model_reset();
        end else begin
            if (hs) begin
                m_valid = 1'b0;
                m_pc    = m_pc + 32'd4;
                if (m_cnt < 65535) m_cnt++;
            end
            if (acc) begin
                m_valid = 1'b1;
                m_instr = nxt_instr;
                m_err   = nxt_err;
            end
        end
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_pc", out_pc, m_pc);
        check("out_count", 32'(out_count), 32'(m_cnt));
        if (m_valid) begin
            check("out_instr", out_instr, m_instr);
            check("out_err", 32'(out_err), 32'(m_err));
        end
    endtask

    initial begin
        bit [31:0] held_instr;
        bit [31:0] held_pc;
        bit        exp_range_err;

`ifdef IMM_RANGE_CHECK_EN
        exp_range_err = 1'b1;
`else
        exp_range_err = 1'b0;
`endif

        reset_n   = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_bundle(3'd0, 7'h0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        check("rst_pc", out_pc, BASE);
        check("rst_count", 32'(out_count), 32'd0);
        reset_n = 1'b1;

        // add x1,x2,x3
        in_valid = 1'b1;
        set_bundle(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        tick();
        check("add_word", out_instr, 32'h003100b3);
        check("add_pc", out_pc, 32'h200);
        check("add_err", 32'(out_err), 32'd0);

        in_valid = 1'b0;
        clear    = 1'b1;
        tick();
        clear = 1'b0;

        // addi x1,x1,1 then sw x1,1(x3), back to back
        in_valid = 1'b1;
        set_bundle(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd1);
        tick();
        check("addi_word", out_instr, 32'h00108093);
        check("addi_pc", out_pc, 32'h200);
        set_bundle(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd3, 5'd1, 32'd1);
        tick();
        check("sw_word", out_instr, 32'h0011a0a3);
        check("sw_pc", out_pc, 32'h204);
        in_valid = 1'b0;
        tick();
        check("count_two", 32'(out_count), 32'd2);

        // jal x1,-16 then beq x1,x1,-24
        in_valid = 1'b1;
        set_bundle(3'd5, 7'h6f, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFF0);
        tick();
        check("jal_word", out_instr, 32'hff1ff0ef);
        set_bundle(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd1, 32'hFFFF_FFE8);
        tick();
        check("beq_word", out_instr, 32'hfe1084e3);

        // Backpressure: word must hold while the consumer stalls
        rand_bundle();
        tick();
        held_instr = out_instr;
        held_pc    = out_pc;
        out_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_bundle();
            tick();
            check("bp_hold_instr", out_instr, held_instr);
            check("bp_hold_pc", out_pc, held_pc);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_bundle();
            tick();
        end

        // Illegal format and immediate range
        set_bundle(3'd7, 7'h33, 3'd5, 7'h7f, 5'd9, 5'd9, 5'd9, 32'h1234_5678);
        tick();
        check("illegal_word", out_instr, 32'h00000013);
        check("illegal_err", 32'(out_err), 32'd1);
        set_bundle(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd4096);
        tick();
        check("addi_4096_err", 32'(out_err), 32'(exp_range_err));
        set_bundle(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd1, 32'd3);
        tick();
        check("beq_odd_err", 32'(out_err), 32'(exp_range_err));
        set_bundle(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd1, 32'd4094);
        tick();
        check("beq_max_err", 32'(out_err), 32'd0);

        // Randomized traffic with random stalls and occasional clears
        for (int i = 0; i < 400; i++) begin
            rand_bundle();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 39) == 0);
            tick();
        end
        clear = 1'b0;

        // Clear coinciding with a handshake and a valid input
        in_valid  = 1'b1;
        out_ready = 1'b1;
        rand_bundle();
        tick();
        check("pre_clear_valid", 32'(out_valid), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_valid", 32'(out_valid), 32'd0);
        check("clear_pc", out_pc, 32'h200);
        check("clear_count", 32'(out_count), 32'd0);
        rand_bundle();
        tick();
        check("post_clear_pc", out_pc, 32'h200);

        // Asynchronous reset mid-stream while a word is held
        out_ready = 1'b0;
        rand_bundle();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_valid", 32'(out_valid), 32'd0);
        check("areset_pc", out_pc, 32'h200);
        check("areset_count", 32'(out_count), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        rand_bundle();
        tick();
        check("post_reset_pc", out_pc, 32'h200);
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encodes RISC-V RV32 instruction fields (format, opcode, funct3/funct7, rs1/rs2/rd, immediate) into 32-bit instruction words.
- It is the inverse of the decoder. It feeds an instruction memory or program buffer during test-program generation and self-checking decode loops.
- It has one registered pipeline stage with valid/ready handshakes on both sides and a running PC counter that tags each emitted word.

Parameters:
- BASE_PC, 32'h0000_0200, PC assigned to the first word after reset or clear.
- PC_STEP, 4, PC increment per emitted word.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous: drop the held word and reload PC to BASE_PC
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept the bundle
- in_fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
- in_opcode  input  7  opcode
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7 (R only)
- in_rd  input  `ARCH_REG_INDEX_SIZE  destination register
- in_rs1  input  `ARCH_REG_INDEX_SIZE  source 1
- in_rs2  input  `ARCH_REG_INDEX_SIZE  source 2
- in_imm  input  `WORD_SIZE  signed immediate/byte offset (U: full value, low 12 bits expected zero)
- out_valid  output  1  encoded word valid
- out_ready  input  1  consumer accepts the word
- out_instr  output  `WORD_SIZE  encoded instruction
- out_pc  output  `WORD_SIZE  PC of out_instr
- out_err  output  1  fmt illegal or immediate out of range
- out_count  output  16  words emitted since reset/clear, saturating at 16'hFFFF

Behaviour:
- Reset (async, reset_n=0): out_valid=0, out_instr=0, out_err=0, out_pc=BASE_PC, out_count=0. Release is synchronous to clk.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready. Output handshake = out_valid && out_ready.
- Latency is 1 cycle: an accepted bundle appears on out_* on the next edge. Full throughput when out_ready=1.
- While out_valid && !out_ready, out_instr, out_pc and out_err are held stable and no input is accepted.
- PC: on each output handshake, out_pc += PC_STEP, wrapping at 2^32. out_pc always names the word currently presented.
- Field placement: opcode always in [6:0]. rd in [11:7] for R/I/U/J. funct3 in [14:12] for R/I/S/B. rs1 in [19:15] for R/I/S/B. rs2 in [24:20] for R/S/B. funct7 in [31:25] for R.
- Immediate placement:
  - I: imm[11:0] goes to [31:20].
  - S: imm[11:5] goes to [31:25]; imm[4:0] goes to [11:7].
  - B: imm[12] goes to [31]; imm[10:5] to [30:25]; imm[4:1] to [11:8]; imm[11] to [7].
  - U: imm[31:12] goes to [31:12].
  - J: imm[20] goes to [31]; imm[10:1] to [30:21]; imm[11] to [20]; imm[19:12] to [19:12].
- Illegal fmt (6,7): emit 32'h0000_0013 (addi x0,x0,0) with out_err=1. The PC still advances.
- clear, together with a handshake: clear wins. out_valid=0, out_pc=BASE_PC, out_count=0, and the input is not accepted that cycle (in_ready forced 0).
- out_count increments on each output handshake and does not wrap.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN.
- Defined: out_err is also set when the immediate does not fit its format:
  - I/S: imm outside [-2048, 2047].
  - B: outside [-4096, 4094], or imm[0]=1.
  - J: outside [-1048576, 1048574], or imm[0]=1.
  - U: imm[11:0] != 0.
  - The word is still emitted with truncated fields.
- Not defined: out_err is set only for illegal fmt, and no range logic is synthesised.

Test Plan:
- R add x1,x2,x3 (fmt=0, op=7'h33, f3=0, f7=0, rd=1, rs1=2, rs2=3), out_ready=1 → next cycle out_instr=32'h003100b3, out_pc=32'h200, out_err=0.
- Back-to-back I addi x1,x1,1 (op=7'h13, imm=1), then S sw x1,1(x3) (op=7'h23, f3=2, rs1=3, rs2=1, imm=1) → 32'h00108093 at pc 0x200, then 32'h0011a0a3 at pc 0x204; out_count=2.
- J jal x1,-16 (op=7'h6f, rd=1, imm=-16), then B beq x1,x1,-24 (op=7'h63, f3=0, imm=-24) → 32'hff1ff0ef, then 32'hfe1084e3.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_instr held constant, out_pc unchanged. Release out_ready → one handshake per cycle, with no word lost or duplicated.
- fmt=7 → out_instr=32'h00000013, out_err=1. With IMM_RANGE_CHECK_EN, addi imm=4096 → out_err=1 and B imm=3 → out_err=1.
- Reset or clear mid-stream with out_valid=1 → out_valid=0, out_pc=32'h200, out_count=0. The next accepted word gets pc 0x200.
